keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 44 ++++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scanner.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Key map is indexed [row][col].
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam logic [3:0] COLS_RST = 4'b1110;

  // Row3 .. Row0, each row listed col3 .. col0
  localparam logic [3:0][3:0][3:0] KEY_MAP = {
    {4'hD, 4'hF, 4'h0, 4'hE},
    {4'hC, 4'h9, 4'h8, 4'h7},
    {4'hB, 4'h6, 4'h5, 4'h4},
    {4'hA, 4'h3, 4'h2, 4'h1}
  };

  function automatic logic [3:0] key_lookup(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return KEY_MAP[row][col];
  endfunction

  function automatic logic [1:0] col_index(
    input logic [3:0] c
  );
    logic [1:0] idx;
    idx = 2'd0;
    unique case (1'b1)
      !c[0]:   idx = 2'd0;
      !c[1]:   idx = 2'd1;
      !c[2]:   idx = 2'd2;
      !c[3]:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs.
// Both stages clear on reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with tick-based debounce
// and a two-digit history for the display driver.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 24000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

  logic [3:0]    rows_s;
  logic [DW-1:0] div;
  logic          tick;

  state_t        state, state_n;
  logic [3:0]    cols_n;
  logic [1:0]    row_idx, row_n;
  logic [1:0]    col_idx, col_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          kv_n;
  logic [3:0]    code_n, dnew_n, dold_n;
  logic [3:0]    code;
  logic          row_low;
  logic          any_low;
  logic [1:0]    low_idx;

  sync_2ff #(
    .WIDTH(4)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rows),
    .q    (rows_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == DIV_LAST);

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_s[i]) low_idx = 2'(i);
    end
  end

  assign any_low = ~&rows_s;
  assign row_low = ~rows_s[row_idx];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign code    = key_lookup(row_idx, col_idx);

  always_comb begin
    state_n = state;
    cols_n  = cols;
    row_n   = row_idx;
    col_n   = col_idx;
    cnt_n   = cnt;
    kv_n    = 1'b0;
    code_n  = key_code;
    dnew_n  = digit_new;
    dold_n  = digit_old;
    unique case (state)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            row_n   = low_idx;
            col_n   = col_index(cols);
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            cols_n = {cols[2:0], cols[3]};
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (row_low) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CNT_DONE) begin
              kv_n    = 1'b1;
              code_n  = code;
              dold_n  = digit_new;
              dnew_n  = code;
              state_n = HELD;
            end
          end else begin
            state_n = SCAN;
          end
        end
      end
      HELD: begin
        if (tick && !row_low) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (tick) begin
          if (row_low) begin
            cnt_n   = '0;
            state_n = HELD;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CNT_DONE) state_n = SCAN;
          end
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      cols      <= COLS_RST;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      state     <= state_n;
      cols      <= cols_n;
      row_idx   <= row_n;
      col_idx   <= col_n;
      cnt       <= cnt_n;
      key_valid <= kv_n;
      key_code  <= code_n;
      digit_new <= dnew_n;
      digit_old <= dold_n;
    end
  end

endmodule
